cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between two result producers: the ALU (ex) and the load path (ld).
- Each producer writes into its own small FIFO. A round-robin arbiter drains the FIFO heads onto one registered CDB broadcast.
- The reservation station, ROB and load/store buffer snoop the broadcast.
- Exposes per-source "next cycle available" back-pressure, with the same semantics as the RS station availability flag.

Parameters:
QDEPTH, 4, entries per source FIFO (power of two, >=2)
QBW, 2, log2(QDEPTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
rdy  input  1  global clock-enable; 0 freezes all state
jump_wrong_stall  input  1  mispredict flush
ex_flag  input  1  ALU result valid this cycle
ex_rob_id  input  32  ROB tag of ALU result
ex_val  input  32  ALU result value
ex_nex_ava  output  1  ex FIFO can accept one push next cycle
ld_flag  input  1  load result valid this cycle
ld_rob_id  input  32  ROB tag of load result
ld_val  input  32  load result value
ld_nex_ava  output  1  ld FIFO can accept one push next cycle
cdb_flag  output  1  broadcast valid
cdb_rob_id  output  32  broadcast ROB tag
cdb_val  output  32  broadcast value
cdb_src  output  1  0 = ex, 1 = ld

Behaviour:

Reset (rst = 0, asynchronous):
- Both FIFOs empty; pointers and counts cleared; last_grant = 1 (ld), so ex wins the first tie.
- Outputs: cdb_flag = 0, cdb_rob_id = 0, cdb_val = 0, cdb_src = 0.

Priority per clock edge: reset, then jump_wrong_stall, then !rdy, then normal operation.

Flush (jump_wrong_stall = 1 at the edge):
- Both FIFOs emptied; same-cycle pushes are dropped.
- cdb_flag <= 0; last_grant <= 1.

rdy = 0:
- No push, no pop, all registers hold, outputs hold.
- Pushes presented that cycle are ignored; the producer is stalled too.

FIFO:
- Circular buffer with head/tail pointers of QBW bits, wrapping naturally modulo QDEPTH.
- Count register of QBW+1 bits.
- Push on src_flag; pop when the source is granted.
- Push and pop in the same cycle: count unchanged.

Arbitration (combinational, from FIFO heads):
- One head non-empty: grant it.
- Both non-empty: grant the source != last_grant.
- last_grant updates only when a grant occurs.
- No grant: cdb_flag <= 0; other cdb outputs hold.

Output:
- The winner's head is registered into cdb_* at the edge; cdb_flag <= 1.
- Latency: push at edge N, appears on the CDB during the cycle after edge N+1 (2 cycles), assuming it wins arbitration.

Back-pressure:
- count_next = count + push - pop
- src_nex_ava = (count_next <= QDEPTH-1), evaluated combinationally from the current cycle's push and pop.
- Producers push only if they sampled nex_ava = 1 in the previous cycle.
- A push into a full FIFO is a protocol violation: the entry is dropped and the simulation-only assertion $display fires.

Throughput:
- One broadcast per cycle.
- With both sources saturated, grants alternate ex, ld, ex, ld...

Optional Feature:
Macro CDB_BYPASS_EN.
- Defined: if a source's FIFO is empty, its flag is high, and it wins arbitration (the incoming request counts as a valid head), its input goes straight into the cdb_* registers without being written to the FIFO. Latency is 1 cycle; count is unchanged.
- Tie-break between a bypass candidate and the other FIFO head is the same round-robin rule.
- Undefined: every result passes through its FIFO; latency is always >= 2 cycles.

Test Plan:
1. Reset release, ex_flag = 1, ex_rob_id = 5, ex_val = 0x11 for one cycle -> cdb_flag = 1, cdb_rob_id = 5, cdb_val = 0x11, cdb_src = 0 exactly 2 cycles later (1 cycle with CDB_BYPASS_EN); cdb_flag = 0 the next cycle.
2. Simultaneous ex (rob 1, val 0xA) and ld (rob 2, val 0xB) on the first cycle after reset -> CDB shows rob 1/src 0, then rob 2/src 1 on consecutive cycles.
3. Both sources push 3 entries each back-to-back -> CDB order is ex0, ld0, ex1, ld1, ex2, ld2 with no idle cycles and no drops.
4. Hold ld idle and push ex every cycle while the bus is busy with ld backlog -> ex_nex_ava deasserts exactly when count_next = QDEPTH; no entry is lost or duplicated.
5. With 3 entries queued in each FIFO, assert jump_wrong_stall for one cycle with a new ex push -> cdb_flag = 0 the next cycle; both nex_ava = 1; nothing is broadcast afterwards.
6. Drop rdy to 0 for 3 cycles mid-stream, then drop rst to 0 asynchronously mid-cycle -> during rdy = 0 the cdb outputs hold their values; on reset, cdb_flag falls immediately without waiting for a clock edge and the FIFOs report empty.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source result FIFOs drained round-robin onto one registered CDB broadcast
// Optional macro CDB_BYPASS_EN: an empty source's incoming result may win the bus directly (1-cycle latency).
`timescale 1ns/1ps
module cdb_arbiter #(
  parameter int QDEPTH = 4,
  parameter int QBW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_stall,
  input  logic        ex_flag,
  input  logic [31:0] ex_rob_id,
  input  logic [31:0] ex_val,
  output logic        ex_nex_ava,
  input  logic        ld_flag,
  input  logic [31:0] ld_rob_id,
  input  logic [31:0] ld_val,
  output logic        ld_nex_ava,
  output logic        cdb_flag,
  output logic [31:0] cdb_rob_id,
  output logic [31:0] cdb_val,
  output logic        cdb_src
);
  localparam logic [QBW:0] FULL_CNT = (QBW+1)'(QDEPTH);
  localparam logic [QBW:0] MAX_AVA  = (QBW+1)'(QDEPTH - 1);

  // index 0 = ex, index 1 = ld throughout
  logic [31:0]    rob_mem [2][QDEPTH];
  logic [31:0]    val_mem [2][QDEPTH];
  logic [QBW-1:0] head [2];
  logic [QBW-1:0] tail [2];
  logic [QBW:0]   count [2];
  logic [QBW:0]   count_next [2];
  logic           last_grant;

  logic           run;
  logic           grant_ex, grant_ld;
  logic [1:0]     in_flag, nonempty, full, byp_cand, req, pop, bypass, wr;
  logic [31:0]    in_rob [2];
  logic [31:0]    in_val [2];
  logic [31:0]    win_rob, win_val;

  assign run = rdy && !jump_wrong_stall;

  always_comb begin
    in_flag   = {ld_flag, ex_flag};
    in_rob[0] = ex_rob_id;
    in_rob[1] = ld_rob_id;
    in_val[0] = ex_val;
    in_val[1] = ld_val;
    for (int s = 0; s < 2; s++) begin
      nonempty[s] = count[s] != '0;
      full[s]     = count[s] == FULL_CNT;
`ifdef CDB_BYPASS_EN
      byp_cand[s] = !nonempty[s] && in_flag[s];
`else
      byp_cand[s] = 1'b0;
`endif
      req[s] = nonempty[s] || byp_cand[s];
    end
    grant_ex = req[0] && (!req[1] || last_grant);
    grant_ld = req[1] && !grant_ex;
    pop[0]    = run && grant_ex && nonempty[0];
    pop[1]    = run && grant_ld && nonempty[1];
    bypass[0] = run && grant_ex && byp_cand[0];
    bypass[1] = run && grant_ld && byp_cand[1];
    for (int s = 0; s < 2; s++) begin
      wr[s] = run && in_flag[s] && !full[s] && !bypass[s];
      count_next[s] = jump_wrong_stall ? '0
                    : count[s] + (QBW+1)'(wr[s]) - (QBW+1)'(pop[s]);
    end
    if (grant_ld) begin
      win_rob = byp_cand[1] ? in_rob[1] : rob_mem[1][head[1]];
      win_val = byp_cand[1] ? in_val[1] : val_mem[1][head[1]];
    end else begin
      win_rob = byp_cand[0] ? in_rob[0] : rob_mem[0][head[0]];
      win_val = byp_cand[0] ? in_val[0] : val_mem[0][head[0]];
    end
  end

  assign ex_nex_ava = count_next[0] <= MAX_AVA;
  assign ld_nex_ava = count_next[1] <= MAX_AVA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      last_grant <= 1'b1;
      cdb_flag   <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= 1'b0;
    end else if (jump_wrong_stall) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      last_grant <= 1'b1;
      cdb_flag   <= 1'b0;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        if (wr[s])  tail[s] <= tail[s] + QBW'(1);
        if (pop[s]) head[s] <= head[s] + QBW'(1);
        count[s] <= count_next[s];
      end
      if (grant_ex || grant_ld) begin
        cdb_flag   <= 1'b1;
        cdb_rob_id <= win_rob;
        cdb_val    <= win_val;
        cdb_src    <= grant_ld;
        last_grant <= grant_ld;
      end else begin
        cdb_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (wr[s]) begin
        rob_mem[s][tail[s]] <= in_rob[s];
        val_mem[s][tail[s]] <= in_val[s];
      end
    end
  end

  // a producer that ignored nex_ava loses its entry here
  push_into_full: assert property (@(posedge clk) disable iff (!rst) !(run && |(in_flag & full)));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - queue-model bench for cdb_arbiter with directed scenarios
`timescale 1ns/1ps
module tb_cdb_arbiter;
  localparam int QDEPTH = 4;
  localparam int QBW    = 2;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, rdy = 1'b0, jws = 1'b0;
  logic ex_flag = 1'b0, ld_flag = 1'b0;
  logic [31:0] ex_rob_id = '0, ex_val = '0, ld_rob_id = '0, ld_val = '0;
  logic ex_nex_ava, ld_nex_ava, cdb_flag, cdb_src;
  logic [31:0] cdb_rob_id, cdb_val;

  cdb_arbiter #(.QDEPTH(QDEPTH), .QBW(QBW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_stall(jws),
    .ex_flag(ex_flag), .ex_rob_id(ex_rob_id), .ex_val(ex_val), .ex_nex_ava(ex_nex_ava),
    .ld_flag(ld_flag), .ld_rob_id(ld_rob_id), .ld_val(ld_val), .ld_nex_ava(ld_nex_ava),
    .cdb_flag(cdb_flag), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: two queues plus round-robin pointer
  typedef struct packed {logic [31:0] rob; logic [31:0] val;} ent_t;
  ent_t exq[$];
  ent_t ldq[$];
  logic        m_flag = 1'b0, m_src = 1'b0, m_last = 1'b1;
  logic [31:0] m_rob = '0, m_val = '0;

  function automatic int winner();
    bit e = (exq.size() > 0) || (BYP && ex_flag);
    bit l = (ldq.size() > 0) || (BYP && ld_flag);
    if (e && l) return m_last ? 0 : 1;
    if (e) return 0;
    if (l) return 1;
    return -1;
  endfunction

  function automatic bit m_ava(input int s);
    int sz = (s == 0) ? exq.size() : ldq.size();
    bit f  = (s == 0) ? ex_flag : ld_flag;
    int w, nxt;
    bit wrote, popped;
    if (jws) return 1'b1;
    if (!rdy) return sz <= QDEPTH - 1;
    w = winner();
    popped = (w == s) && (sz > 0);
    wrote  = f && !((w == s) && (sz == 0)) && (sz < QDEPTH);
    nxt = sz + int'(wrote) - int'(popped);
    return nxt <= QDEPTH - 1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int w, exsz, ldsz;
    bit exb, ldb;
    ent_t e;
    if (!rst) begin
      exq.delete(); ldq.delete();
      m_flag <= 1'b0; m_rob <= '0; m_val <= '0; m_src <= 1'b0; m_last <= 1'b1;
    end else if (jws) begin
      exq.delete(); ldq.delete();
      m_flag <= 1'b0; m_last <= 1'b1;
    end else if (rdy) begin
      w = winner(); exsz = exq.size(); ldsz = ldq.size(); exb = 1'b0; ldb = 1'b0;
      if (w == 0) begin
        if (exsz > 0) e = exq.pop_front();
        else begin e = '{ex_rob_id, ex_val}; exb = 1'b1; end
        m_flag <= 1'b1; m_rob <= e.rob; m_val <= e.val; m_src <= 1'b0; m_last <= 1'b0;
      end else if (w == 1) begin
        if (ldsz > 0) e = ldq.pop_front();
        else begin e = '{ld_rob_id, ld_val}; ldb = 1'b1; end
        m_flag <= 1'b1; m_rob <= e.rob; m_val <= e.val; m_src <= 1'b1; m_last <= 1'b1;
      end else begin
        m_flag <= 1'b0;
      end
      if (ex_flag && !exb && exsz < QDEPTH) exq.push_back('{ex_rob_id, ex_val});
      if (ld_flag && !ldb && ldsz < QDEPTH) ldq.push_back('{ld_rob_id, ld_val});
    end
  end

  bit cmp_en = 1'b0;
  int ex_bc = 0, ld_bc = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk1("cmp_cdb_flag", cdb_flag, m_flag);
      chk("cmp_cdb_rob_id", cdb_rob_id, m_rob);
      chk("cmp_cdb_val", cdb_val, m_val);
      chk1("cmp_cdb_src", cdb_src, m_src);
      chk1("cmp_ex_nex_ava", ex_nex_ava, m_ava(0));
      chk1("cmp_ld_nex_ava", ld_nex_ava, m_ava(1));
    end
    if (cdb_flag) begin
      if (cdb_src) ld_bc++;
      else ex_bc++;
    end
  end

  // ---------------- stimulus helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ef, input logic [31:0] er, input logic [31:0] ev,
                       input logic lf, input logic [31:0] lr, input logic [31:0] lv);
    ex_flag = ef; ex_rob_id = er; ex_val = ev;
    ld_flag = lf; ld_rob_id = lr; ld_val = lv;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] v(input int r);
    return 32'(r) + 32'h1000;
  endfunction

  int exp3 [6] = '{10, 20, 11, 21, 12, 22};
  int n_ex, n_ld;
  bit ex_ok, ld_ok, saw_low, ef, lf;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    chk1("rst_cdb_flag", cdb_flag, 1'b0);
    chk("rst_cdb_rob_id", cdb_rob_id, 32'd0);
    chk("rst_cdb_val", cdb_val, 32'd0);
    chk1("rst_cdb_src", cdb_src, 1'b0);
    chk1("rst_ex_nex_ava", ex_nex_ava, 1'b1);
    chk1("rst_ld_nex_ava", ld_nex_ava, 1'b1);
    rdy = 1'b1; rst = 1'b1; cmp_en = 1'b1;

    // single ex result
    drive(1, 5, 32'h11, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    repeat (LAT - 1) cyc();
    chk1("t1_flag", cdb_flag, 1'b1);
    chk("t1_rob", cdb_rob_id, 32'd5);
    chk("t1_val", cdb_val, 32'h11);
    chk1("t1_src", cdb_src, 1'b0);
    cyc();
    chk1("t1_idle", cdb_flag, 1'b0);

    // simultaneous first results: ex wins the tie
    do_reset();
    drive(1, 1, 32'hA, 1, 2, 32'hB);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    repeat (LAT - 1) cyc();
    chk("t2_rob0", cdb_rob_id, 32'd1);
    chk1("t2_src0", cdb_src, 1'b0);
    cyc();
    chk("t2_rob1", cdb_rob_id, 32'd2);
    chk("t2_val1", cdb_val, 32'hB);
    chk1("t2_src1", cdb_src, 1'b1);

    // three back-to-back from each source alternate with no gaps
    do_reset();
    for (int c = 0; c < LAT + 5; c++) begin
      if (c < 3) drive(1, 10 + c, v(10 + c), 1, 20 + c, v(20 + c));
      else drive(0, 0, 0, 0, 0, 0);
      cyc();
      if (c + 1 >= LAT) begin
        chk1("t3_flag", cdb_flag, 1'b1);
        chk("t3_rob", cdb_rob_id, 32'(exp3[c + 1 - LAT]));
        chk1("t3_src", cdb_src, 1'((c + 1 - LAT) % 2));
      end
    end
    cyc();
    chk1("t3_idle", cdb_flag, 1'b0);

    // ex saturates behind an ld backlog; producers honour nex_ava
    do_reset();
    ex_bc = 0; ld_bc = 0; n_ex = 0; n_ld = 0; saw_low = 0; ex_ok = 1; ld_ok = 1;
    for (int c = 0; c < 24; c++) begin
      ef = (c < 14) && ex_ok;
      lf = (c < 4) && ld_ok;
      drive(ef, 100 + n_ex, v(100 + n_ex), lf, 200 + n_ld, v(200 + n_ld));
      if (ef) n_ex++;
      if (lf) n_ld++;
      #2;
      ex_ok = ex_nex_ava; ld_ok = ld_nex_ava;
      if (!ex_ok) saw_low = 1;
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cyc();
    chk("t4_ex_bcast", 32'(ex_bc), 32'(n_ex));
    chk("t4_ld_bcast", 32'(ld_bc), 32'(n_ld));
    chk1("t4_ex_ava_low_seen", saw_low, 1'b1);

    // flush with queued entries and a same-cycle push
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1, 50 + c, v(50 + c), 1, 60 + c, v(60 + c));
      cyc();
    end
    jws = 1'b1;
    drive(1, 77, v(77), 0, 0, 0);
    cyc();
    jws = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk1("t5_flag", cdb_flag, 1'b0);
    chk1("t5_ex_ava", ex_nex_ava, 1'b1);
    chk1("t5_ld_ava", ld_nex_ava, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk1("t5_quiet", cdb_flag, 1'b0);
    end

    // rdy stall holds the bus, then async reset mid-cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 30 + c, v(30 + c), 1, 40 + c, v(40 + c));
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk1("t6_pre_flag", cdb_flag, 1'b1);
    rdy = 1'b0;
    drive(1, 99, v(99), 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk1("t6_hold_flag", cdb_flag, 1'b1);
      chk("t6_hold_rob", cdb_rob_id, (LAT == 2) ? 32'd31 : 32'd41);
      chk("t6_hold_val", cdb_val, (LAT == 2) ? v(31) : v(41));
      chk1("t6_hold_src", cdb_src, (LAT == 2) ? 1'b0 : 1'b1);
    end
    rdy = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk1("t6_resume_flag", cdb_flag, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("t6_async_flag", cdb_flag, 1'b0);
    chk("t6_async_rob", cdb_rob_id, 32'd0);
    chk1("t6_async_ex_ava", ex_nex_ava, 1'b1);
    chk1("t6_async_ld_ava", ld_nex_ava, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
